// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scan decoder
package keypad_pkg;

  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAND    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_REL     = 2'd3
  } key_state_e;

  typedef enum logic [1:0] {
    RES_NONE     = 2'd0,
    RES_KEY      = 2'd1,
    RES_CONFLICT = 2'd2
  } round_res_e;

  localparam logic [3:0] ROW0_N   = 4'b1110;
  localparam logic [3:0] ROW1_N   = 4'b1101;
  localparam logic [3:0] ROW2_N   = 4'b1011;
  localparam logic [3:0] ROW3_N   = 4'b0111;
  localparam logic [3:0] COL_OPEN = 4'b1111;

  // Index of the single low bit of an active-low one-hot nibble.
  function automatic logic [1:0] onehot_n_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/keypad_round_collector.sv
// rtl/keypad_round_collector.sv - folds one scan round of row/col samples into a single result
module keypad_round_collector
  import keypad_pkg::*;
(
  input  logic                  keypad_clk,
  input  logic                  reset,
  input  logic [3:0]            keypad_row,
  input  logic [3:0]            keypad_col,
  output logic                  round_end,
  output round_res_e            round_result,
  output logic [KEY_CODE_W-1:0] round_code
);

  logic                  hit_q, hit_d;
  logic                  conf_q, conf_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;

  logic                  row_valid;
  logic [3:0]            col_low;
  logic                  one_low;
  logic                  multi_low;
  logic                  sample_hit;
  logic [KEY_CODE_W-1:0] sample_code;
  logic                  m_hit, m_conf;
  logic [KEY_CODE_W-1:0] m_code;

  always_comb begin
    row_valid = (keypad_row == ROW0_N) || (keypad_row == ROW1_N) ||
                (keypad_row == ROW2_N) || (keypad_row == ROW3_N);
    col_low     = ~keypad_col;
    one_low     = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);
    multi_low   = row_valid && (col_low != 4'd0) && !one_low;
    sample_hit  = row_valid && one_low;
    sample_code = {onehot_n_index(keypad_row), onehot_n_index(keypad_col)};

    // The round result includes the sample taken on the round-ending edge.
    m_hit  = hit_q | sample_hit;
    m_conf = conf_q | multi_low | (hit_q & sample_hit);
    m_code = hit_q ? code_q : sample_code;

    round_end    = row_valid && (keypad_row == ROW3_N);
    round_code   = m_code;
    round_result = m_conf ? RES_CONFLICT : (m_hit ? RES_KEY : RES_NONE);

    hit_d  = hit_q;
    conf_d = conf_q;
    code_d = code_q;
    if (round_end) begin
      hit_d  = 1'b0;
      conf_d = 1'b0;
      code_d = '0;
    end else if (row_valid) begin
      hit_d  = m_hit;
      conf_d = m_conf;
      code_d = m_code;
    end
  end

  always_ff @(posedge keypad_clk or negedge reset) begin
    if (!reset) begin
      hit_q  <= 1'b0;
      conf_q <= 1'b0;
      code_q <= '0;
    end else begin
      hit_q  <= hit_d;
      conf_q <= conf_d;
      code_q <= code_d;
    end
  end

endmodule

// File: rtl/keypad_scan_decoder.sv
// rtl/keypad_scan_decoder.sv - debounced 4x4 keypad decoder with press/release filtering
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_ROUNDS = 2,
  parameter int RELEASE_ROUNDS  = 2
) (
  input  logic                  keypad_clk,
  input  logic                  reset,
  input  logic [3:0]            keypad_row,
  input  logic [3:0]            keypad_col,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_ROUNDS);
  localparam logic [3:0] REL_N = 4'(RELEASE_ROUNDS);

  logic                  round_end;
  round_res_e            round_result;
  logic [KEY_CODE_W-1:0] round_code;

  key_state_e            state_q, state_d;
  logic [KEY_CODE_W-1:0] cand_q, cand_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            rcnt_q, rcnt_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;

  keypad_round_collector u_collector (
    .keypad_clk   (keypad_clk),
    .reset        (reset),
    .keypad_row   (keypad_row),
    .keypad_col   (keypad_col),
    .round_end    (round_end),
    .round_result (round_result),
    .round_code   (round_code)
  );

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    if (round_end) begin
      unique case (state_q)
        ST_IDLE, ST_CAND: begin
          if (round_result == RES_KEY) begin
            if (state_q == ST_CAND && round_code == cand_q) begin
              cnt_d = sat_inc(cnt_q);
            end else begin
              cand_d = round_code;
              cnt_d  = 4'd1;
            end
            // Acceptance always latches the code that earned the count.
            if (cnt_d >= DEB_N) begin
              state_d     = ST_PRESSED;
              key_code_d  = cand_d;
              key_valid_d = 1'b1;
              rcnt_d      = 4'd0;
            end else begin
              state_d = ST_CAND;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
        ST_PRESSED: begin
          if (round_result == RES_NONE) begin
            rcnt_d  = 4'd1;
            state_d = (rcnt_d >= REL_N) ? ST_IDLE : ST_REL;
          end
        end
        ST_REL: begin
          if (round_result == RES_NONE) begin
            rcnt_d = sat_inc(rcnt_q);
            if (rcnt_d >= REL_N) state_d = ST_IDLE;
          end else if (round_result == RES_KEY && round_code == key_code_q) begin
            state_d = ST_PRESSED;
            rcnt_d  = 4'd0;
          end else begin
            rcnt_d = 4'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge keypad_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= 4'd0;
      rcnt_q      <= 4'd0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == ST_PRESSED) || (state_q == ST_REL);

endmodule
